// File: rtl/msaa_sample_iter_if.sv
// Triangle/box in, sample stream out, with halt in both directions.
// The master modport is the side that drives the triangle and the downstream halt.
interface msaa_sample_iter_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int SSW    = 2
);
    logic [VERTS*AXIS*SIGFIG-1:0] tri_in;
    logic                         valid_tri_in;
    logic [4*SIGFIG-1:0]          box_in;
    logic [SSW-1:0]               ss_log2;
    logic                         halt_in;
    logic                         halt_out;
    logic [VERTS*AXIS*SIGFIG-1:0] tri_out;
    logic [2*SIGFIG-1:0]          sample_out;
    logic                         valid_samp_out;
    logic                         last_samp_out;

    modport master (
        output tri_in, valid_tri_in, box_in, ss_log2, halt_in,
        input  halt_out, tri_out, sample_out, valid_samp_out, last_samp_out
    );

    modport slave (
        input  tri_in, valid_tri_in, box_in, ss_log2, halt_in,
        output halt_out, tri_out, sample_out, valid_samp_out, last_samp_out
    );
endinterface

// File: rtl/msaa_sample_iter.sv
// Walks every supersample position of a snapped bounding box in raster order,
// at 2^ss_log2 samples per pixel axis, one sample per cycle unless halted.
//
// state | meaning
// ------+-------------------------------------------------------------
// WAIT  | idle; accepts a triangle with a valid box, drops invalid boxes
// TEST  | emitting samples; upstream stalled via halt_out
module msaa_sample_iter #(
    parameter int SIGFIG      = 24,
    parameter int RADIX       = 10,
    parameter int VERTS       = 3,
    parameter int AXIS        = 3,
    parameter int SS_LOG2_MAX = 2,
    parameter int SSW         = 2
) (
    input  logic             clk,
    input  logic             rst,
    msaa_sample_iter_if.slave bus
);
    localparam int TW = VERTS * AXIS * SIGFIG;

    typedef enum logic {WAIT, TEST} state_t;

    state_t                   state;
    logic [TW-1:0]            tri_q;
    logic                     valid_q;
    logic signed [SIGFIG-1:0] llx, urx, ury, x, y;
    logic [SIGFIG-1:0]        step;

    logic signed [SIGFIG-1:0] in_llx, in_lly, in_urx, in_ury;
    logic                     box_ok;
    logic [SSW-1:0]           eff;
    logic [SIGFIG-1:0]        step_new;
    logic signed [SIGFIG:0]   nx, ny, urx_w, ury_w;
    logic                     x_end, y_end;

    always_comb begin
        in_llx   = bus.box_in[SIGFIG-1:0];
        in_lly   = bus.box_in[2*SIGFIG-1:SIGFIG];
        in_urx   = bus.box_in[3*SIGFIG-1:2*SIGFIG];
        in_ury   = bus.box_in[4*SIGFIG-1:3*SIGFIG];
        box_ok   = (in_urx >= in_llx) && (in_ury >= in_lly);
        eff      = (32'(bus.ss_log2) > SS_LOG2_MAX) ? SSW'(SS_LOG2_MAX) : bus.ss_log2;
        step_new = SIGFIG'(1) << (RADIX - 32'(eff));
        // One extra bit so stepping past the upper corner never wraps negative.
        nx       = {x[SIGFIG-1], x} + {1'b0, step};
        ny       = {y[SIGFIG-1], y} + {1'b0, step};
        urx_w    = {urx[SIGFIG-1], urx};
        ury_w    = {ury[SIGFIG-1], ury};
        x_end    = nx > urx_w;
        y_end    = ny > ury_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT;
            valid_q <= 1'b0;
            tri_q   <= '0;
            llx     <= '0;
            urx     <= '0;
            ury     <= '0;
            x       <= '0;
            y       <= '0;
            step    <= '0;
        end else begin
            case (state)
                WAIT: begin
                    if (bus.valid_tri_in && box_ok) begin
                        tri_q   <= bus.tri_in;
                        llx     <= in_llx;
                        urx     <= in_urx;
                        ury     <= in_ury;
                        step    <= step_new;
                        x       <= in_llx;
                        y       <= in_lly;
                        valid_q <= 1'b1;
                        state   <= TEST;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                TEST: begin
                    if (!bus.halt_in) begin
                        if (!x_end) begin
                            x <= nx[SIGFIG-1:0];
                        end else if (!y_end) begin
                            x <= llx;
                            y <= ny[SIGFIG-1:0];
                        end else begin
                            valid_q <= 1'b0;
                            state   <= WAIT;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= WAIT;
                end
            endcase
        end
    end

    assign bus.halt_out       = (state == TEST);
    assign bus.tri_out        = tri_q;
    assign bus.sample_out     = {y, x};
    assign bus.valid_samp_out = valid_q;
    assign bus.last_samp_out  = valid_q && x_end && y_end;
endmodule

// File: tb/tb_msaa_sample_iter.sv
// Directed bench for msaa_sample_iter: a queue of expected samples per triangle
// is built from the box and rate, then checked against the DUT every cycle.
module tb_msaa_sample_iter;
    localparam int SIGFIG      = 24;
    localparam int RADIX       = 10;
    localparam int VERTS       = 3;
    localparam int AXIS        = 3;
    localparam int SS_LOG2_MAX = 2;
    localparam int SSW         = 2;
    localparam int TW          = VERTS * AXIS * SIGFIG;

    logic clk = 1'b0;
    logic rst = 1'b1;

    msaa_sample_iter_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .SSW(SSW)) bus ();

    msaa_sample_iter #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS),
        .SS_LOG2_MAX(SS_LOG2_MAX), .SSW(SSW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] yx;
        logic        last;
    } samp_t;

    int          n_chk = 0;
    int          n_fail = 0;
    samp_t       q[$];
    logic [TW-1:0] exp_tri = '0;
    bit          rst_flag = 1'b0;
    bit          chk_en = 1'b0;
    int          fill_cnt = 0;
    logic [47:0] log_q[$];
    int          halt_cnt = 0;
    int          last_cnt = 0;

    task automatic chk(string name, logic [TW-1:0] act, logic [TW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every sample position of the box, raster order, last flagged on the final one.
    function automatic void model_fill(logic [TW-1:0] t, int llx, int lly, int urx, int ury, int ss);
        int    eff;
        int    step;
        samp_t s;
        if (urx < llx || ury < lly) return;
        eff  = (ss > SS_LOG2_MAX) ? SS_LOG2_MAX : ss;
        step = 1 << (RADIX - eff);
        for (int yy = lly; yy <= ury; yy += step)
            for (int xx = llx; xx <= urx; xx += step) begin
                s.yx   = {24'(yy), 24'(xx)};
                s.last = 1'b0;
                q.push_back(s);
            end
        s = q[q.size()-1];
        s.last = 1'b1;
        q[q.size()-1] = s;
        fill_cnt = q.size();
        exp_tri  = t;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            exp_tri  = '0;
            rst_flag = 1'b1;
        end else if (q.size() == 0) begin
            if (bus.valid_tri_in)
                model_fill(bus.tri_in,
                           $signed(bus.box_in[23:0]),  $signed(bus.box_in[47:24]),
                           $signed(bus.box_in[71:48]), $signed(bus.box_in[95:72]),
                           int'(bus.ss_log2));
        end else if (!bus.halt_in) begin
            void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (rst_flag) begin
                chk("rst_sample", bus.sample_out, '0);
                chk("rst_tri", bus.tri_out, '0);
                rst_flag = 1'b0;
            end
            chk("valid", bus.valid_samp_out, q.size() != 0);
            chk("halt_out", bus.halt_out, q.size() != 0);
            if (q.size() != 0) begin
                chk("sample", bus.sample_out, q[0].yx);
                chk("last", bus.last_samp_out, q[0].last);
                chk("tri", bus.tri_out, exp_tri);
            end else begin
                chk("last_idle", bus.last_samp_out, 1'b0);
            end
            if (bus.halt_out) halt_cnt++;
            if (bus.valid_samp_out && !bus.halt_in) begin
                log_q.push_back(bus.sample_out);
                if (bus.last_samp_out) last_cnt++;
            end
        end
    end

    function automatic logic [TW-1:0] tri_pat(int seed);
        logic [TW-1:0] t;
        t = '0;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                t[(v*AXIS+a)*SIGFIG +: SIGFIG] = 24'(seed*100 + v*10 + a);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_log();
        log_q.delete();
        halt_cnt = 0;
        last_cnt = 0;
    endtask

    task automatic send(int llx, int lly, int urx, int ury, int ss, logic [TW-1:0] t);
        bus.tri_in       = t;
        bus.box_in       = {24'(ury), 24'(urx), 24'(lly), 24'(llx)};
        bus.ss_log2      = SSW'(ss);
        bus.valid_tri_in = 1'b1;
        tick();
        bus.valid_tri_in = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0) break;
            tick();
        end
        chk("timeout", q.size(), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.tri_in       = '0;
        bus.valid_tri_in = 1'b0;
        bus.box_in       = '0;
        bus.ss_log2      = '0;
        bus.halt_in      = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        tick();

        // 3x3 grid at half-pixel step
        clr_log();
        send(0, 0, 1024, 1024, 1, tri_pat(1));
        chk("first_latency", bus.valid_samp_out, 1'b1);
        wait_done();
        chk("t1_count", log_q.size(), 9);
        chk("t1_model_count", fill_cnt, 9);
        chk("t1_s1", log_q[1], {24'd0, 24'd512});
        chk("t1_s3", log_q[3], {24'd512, 24'd0});
        chk("t1_s8", log_q[8], {24'd1024, 24'd1024});
        chk("t1_halt_cycles", halt_cnt, 9);
        chk("t1_last_count", last_cnt, 1);

        // quarter-pixel row, then same with rate above the maximum
        clr_log();
        send(0, 0, 768, 0, 2, tri_pat(2));
        wait_done();
        chk("t2_count", log_q.size(), 4);
        chk("t2_s3", log_q[3], {24'd0, 24'd768});
        clr_log();
        send(0, 0, 768, 0, 3, tri_pat(3));
        wait_done();
        chk("t2c_count", log_q.size(), 4);
        chk("t2c_s1", log_q[1], {24'd0, 24'd256});

        // negative coordinates
        clr_log();
        send(-1024, -512, -512, -512, 0, tri_pat(4));
        wait_done();
        chk("t3_count", log_q.size(), 1);
        chk("t3_s0", log_q[0], {24'hFFFE00, 24'hFFFC00});
        chk("t3_last_count", last_cnt, 1);
        clr_log();
        send(-1024, -512, -512, -512, 1, tri_pat(5));
        wait_done();
        chk("t3b_count", log_q.size(), 2);
        chk("t3b_s1", log_q[1], {24'hFFFE00, 24'hFFFE00});

        // downstream halt on the second sample
        clr_log();
        send(0, 0, 512, 512, 1, tri_pat(6));
        tick();
        bus.halt_in = 1'b1;
        tick();
        tick();
        tick();
        chk("t4_frozen", bus.sample_out, {24'd0, 24'd512});
        bus.halt_in = 1'b0;
        wait_done();
        chk("t4_count", log_q.size(), 4);
        chk("t4_s1", log_q[1], {24'd0, 24'd512});
        chk("t4_s2", log_q[2], {24'd512, 24'd0});
        chk("t4_halt_cycles", halt_cnt, 7);

        // inverted box dropped, next triangle accepted straight away
        clr_log();
        send(1024, 0, 0, 0, 0, tri_pat(7));
        chk("t5_drop_valid", bus.valid_samp_out, 1'b0);
        chk("t5_drop_halt", bus.halt_out, 1'b0);
        send(0, 0, 0, 0, 0, tri_pat(8));
        chk("t5_accept", bus.valid_samp_out, 1'b1);
        chk("t5_single_last", bus.last_samp_out, 1'b1);
        wait_done();
        chk("t5_count", log_q.size(), 1);

        // reset on the third sample
        clr_log();
        send(0, 0, 1024, 1024, 1, tri_pat(9));
        tick();
        tick();
        chk("t6_third", bus.sample_out, {24'd0, 24'd1024});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_valid", bus.valid_samp_out, 1'b0);
        chk("t6_rst_halt", bus.halt_out, 1'b0);
        chk("t6_rst_sample", bus.sample_out, '0);
        clr_log();
        send(-2048, 3072, -1024, 3072, 0, tri_pat(10));
        wait_done();
        chk("t6_count", log_q.size(), 2);
        chk("t6_s0", log_q[0], {24'd3072, 24'hFFF800});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
